mem_fetch_unit: RTL

//  Memory-side counterpart of the multicycle control decoder. It owns PC, OldPC, the

---
 rtl/proc_pkg.sv | 39 +++
 rtl/mem_fetch_unit_if.sv | 28 ++
 rtl/mem_fetch_unit_timeout_ctr.sv | 39 +++
 rtl/mem_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared types and opcodes for the control decoder and the
//                memory fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        ACC_FETCH = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } acc_kind_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;

    // Fetches only need 4-byte alignment; data accesses are full doublewords.
    function automatic logic misaligned(input acc_kind_t kind, input logic [2:0] lsb);
        if (kind == ACC_FETCH)
            return (lsb[1:0] != 2'b00);
        return (lsb != 3'b000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_fetch_unit_if
//  Description : Unified instruction/data memory request/response bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_fetch_unit_if #(
    parameter int XLEN = 64
) ();
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_fetch_unit_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_timeout_ctr
//  Description : Counts wait cycles and flags the cycle in which the limit is hit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      expire_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Asserted during the TIMEOUT-th consecutive enabled cycle.
    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_fetch_unit
//  Description : Owns PC/OldPC/IR/MDR and runs fetch, load and store accesses
//                on the unified memory port for the multicycle control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_fetch_unit
    import proc_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 255
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            PCwrite,
    input  wire logic [XLEN-1:0] pc_next,
    input  wire logic            AdrSrc,
    input  wire logic [XLEN-1:0] alu_addr,
    input  wire logic            Irwrite,
    input  wire logic            MemRead,
    input  wire logic            MemWrite,
    input  wire logic [XLEN-1:0] wdata_in,
    output logic                 busy,
    output logic                 done,
    output logic                 bus_err,
    output logic [ILEN-1:0]      inst,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      old_pc,
    output logic [XLEN-1:0]      mdr,
    mem_fetch_unit_if.master     mem
);
    mem_state_t      state_q, state_d;
    acc_kind_t       kind_q, kind_d;
    logic            hi_q, hi_d;
    logic [XLEN-1:0] pcs_q, pcs_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] old_pc_q, old_pc_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic [XLEN-1:0] w_addr;
    logic [1:0]      w_nstart;
    acc_kind_t       w_kind;
    logic            w_capture;
    logic            w_expire;

    assign w_addr   = AdrSrc ? alu_addr : pc_q;
    assign w_nstart = {1'b0, Irwrite} + {1'b0, MemRead} + {1'b0, MemWrite};
    assign w_kind   = Irwrite ? ACC_FETCH : (MemRead ? ACC_LOAD : ACC_STORE);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != WAIT),
        .en_i     (state_q == WAIT),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        hi_d      = hi_q;
        pcs_d     = pcs_q;
        old_pc_d  = old_pc_q;
        inst_d    = inst_q;
        mdr_d     = mdr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        w_capture = 1'b0;
        pc_d      = PCwrite ? pc_next : pc_q;

        case (state_q)
            IDLE: begin
                if (w_nstart != 2'd0) begin
                    if ((w_nstart > 2'd1) || misaligned(w_kind, w_addr[2:0])) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        kind_d  = w_kind;
                        hi_d    = w_addr[2];
                        pcs_d   = pc_q;
                        busy_d  = 1'b1;
                        req_d   = 1'b1;
                        we_d    = (w_kind == ACC_STORE);
                        addr_d  = {w_addr[XLEN-1:3], 3'b000};
                        wdata_d = wdata_in;
                    end
                end
            end
            REQ: begin
                if (mem.mem_gnt) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    // A read whose data arrives with the grant skips WAIT.
                    if (kind_q == ACC_STORE || mem.mem_rvalid) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        w_capture = (kind_q != ACC_STORE);
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    w_capture = 1'b1;
                end else if (w_expire) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase

        if (w_capture) begin
            if (kind_q == ACC_FETCH) begin
                inst_d   = hi_q ? mem.mem_rdata[2*ILEN-1:ILEN] : mem.mem_rdata[ILEN-1:0];
                old_pc_d = pcs_q;
            end else begin
                mdr_d = mem.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            kind_q   <= ACC_FETCH;
            hi_q     <= 1'b0;
            pcs_q    <= '0;
            pc_q     <= RESET_PC;
            old_pc_q <= '0;
            inst_q   <= '0;
            mdr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            hi_q     <= hi_d;
            pcs_q    <= pcs_d;
            pc_q     <= pc_d;
            old_pc_q <= old_pc_d;
            inst_q   <= inst_d;
            mdr_q    <= mdr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus_err       = err_q;
    assign inst          = inst_q;
    assign pc            = pc_q;
    assign old_pc        = old_pc_q;
    assign mdr           = mdr_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule
`default_nettype wire
